// File: rtl/vga_timing_monitor.sv
// Passive sink-side checker for the XGA 1024x768@60 raster: measures sync timing, tracks lock and
// sticky errors, and publishes per-frame stats. VGA_MON_CHECKSUM_EN adds the active-pixel checksum.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 1344,
  parameter int H_SYNC      = 136,
  parameter int V_TOTAL     = 806,
  parameter int V_SYNC      = 6,
  parameter int H_FIRST     = 296,
  parameter int V_FIRST     = 35,
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        locked,
  output logic        frame_done,
  output logic [10:0] h_total_m,
  output logic [10:0] h_sync_m,
  output logic [9:0]  v_total_m,
  output logic [9:0]  v_sync_m,
  output logic [15:0] frame_checksum,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] frame_cnt
);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0]   H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0]   H_SYNC_C  = 11'(H_SYNC);
  localparam logic [9:0]    V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0]    V_SYNC_C  = 10'(V_SYNC);
  localparam logic [LW-1:0] LOCK_C    = LW'(LOCK_FRAMES);

  typedef enum logic {SEARCH = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nx;

  logic hs1, hs2, vs1, vs2;
  logic hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] h_cnt, h_period, h_line, h_sync_w;
  logic [9:0]  v_cnt, v_period, v_sync_w;
  logic h_sat, v_sat, line_bad, frame_mis, h_bad, v_bad;
  logic frame_bad, frame_clean, publish;
  logic [LW-1:0] lock_cnt;

  // Syncs reset low so a sync already low at release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1 <= 1'b0;
      hs2 <= 1'b0;
      vs1 <= 1'b0;
      vs2 <= 1'b0;
    end else begin
      hs1 <= hs;
      hs2 <= hs1;
      vs1 <= vs;
      vs2 <= vs1;
    end
  end

  assign hs_fall  = hs2 & ~hs1;
  assign hs_rise  = ~hs2 & hs1;
  assign vs_fall  = vs2 & ~vs1;
  assign vs_rise  = ~vs2 & vs1;
  assign h_sat    = (h_cnt == 11'h7FF);
  assign v_sat    = (v_cnt == 10'h3FF);
  assign h_period = h_sat ? h_cnt : h_cnt + 11'd1;
  assign v_period = v_sat ? v_cnt : v_cnt + 10'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      h_line   <= '0;
      h_sync_w <= '0;
      v_sync_w <= '0;
    end else begin
      h_cnt <= hs_fall ? 11'd0 : h_period;
      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall)
        v_cnt <= v_period;
      if (hs_fall) h_line   <= h_period;
      if (hs_rise) h_sync_w <= h_period;
      if (vs_rise) v_sync_w <= v_cnt;
    end
  end

  assign line_bad    = hs_fall && ((h_period != H_TOTAL_C) || (h_sync_w != H_SYNC_C));
  assign frame_mis   = vs_fall && ((v_period != V_TOTAL_C) || (v_sync_w != V_SYNC_C));
  assign h_bad       = line_bad || h_sat;
  assign v_bad       = frame_mis || v_sat;
  assign frame_clean = !frame_bad && !h_bad && !v_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    publish  = 1'b0;
    case (state)
      SEARCH: if (vs_fall) state_nx = RUN;
      RUN:    publish = vs_fall;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      err_h      <= 1'b0;
      err_v      <= 1'b0;
      frame_bad  <= 1'b0;
      lock_cnt   <= '0;
      h_total_m  <= '0;
      h_sync_m   <= '0;
      v_total_m  <= '0;
      v_sync_m   <= '0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= publish;
      if (state == RUN && h_bad) err_h <= 1'b1;
      if (state == RUN && v_bad) err_v <= 1'b1;
      if (vs_fall)
        frame_bad <= 1'b0;
      else if (state == RUN && (h_bad || v_bad))
        frame_bad <= 1'b1;
      if (publish) begin
        // The closing line usually ends on this same edge, so take its period directly.
        h_total_m <= hs_fall ? h_period : h_line;
        h_sync_m  <= h_sync_w;
        v_total_m <= v_period;
        v_sync_m  <= v_sync_w;
        frame_cnt <= frame_cnt + 16'd1;
        if (!frame_clean)
          lock_cnt <= '0;
        else if (lock_cnt != LOCK_C)
          lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  assign locked = (lock_cnt == LOCK_C);

`ifdef VGA_MON_CHECKSUM_EN
  localparam logic [10:0] H_FIRST_C = 11'(H_FIRST);
  localparam logic [10:0] H_LAST_C  = 11'(H_FIRST + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST_C = 10'(V_FIRST);
  localparam logic [9:0]  V_LAST_C  = 10'(V_FIRST + V_ACTIVE - 1);

  logic [11:0] rgb1, rgb2;
  logic [15:0] csum;
  logic        active;

  // rgb2 lines up with h_cnt/v_cnt, so the counters index the pixel being folded in.
  assign active = (h_cnt >= H_FIRST_C) && (h_cnt <= H_LAST_C) &&
                  (v_cnt >= V_FIRST_C) && (v_cnt <= V_LAST_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb1           <= '0;
      rgb2           <= '0;
      csum           <= '0;
      frame_checksum <= '0;
    end else begin
      rgb1 <= {r, g, b};
      rgb2 <= rgb1;
      if (publish) frame_checksum <= csum;
      if (vs_fall)
        csum <= '0;
      else if (active)
        csum <= {csum[14:0], csum[15]} ^ {4'h0, rgb2};
    end
  end
`else
  localparam int unused_geom = H_FIRST + H_ACTIVE + V_FIRST + V_ACTIVE;
  logic unused_rgb;
  assign unused_rgb     = ^{r, g, b};
  assign frame_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a scaled-down raster; each vs edge pushes the expected published
// frame stats to a scoreboard that is popped and compared whenever frame_done fires.
module tb_vga_timing_monitor;
  localparam int HT = 40, HSW = 4, VT = 20, VSW = 2;
  localparam int HF = 10, VF = 5, HA = 24, VA = 12, LOCKN = 2;

  logic clk = 1'b0;
  logic rst, hs, vs;
  logic [3:0] r, g, b;
  logic locked, frame_done, err_h, err_v;
  logic [10:0] h_total_m, h_sync_m;
  logic [9:0] v_total_m, v_sync_m;
  logic [15:0] frame_checksum, frame_cnt;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HSW), .V_TOTAL(VT), .V_SYNC(VSW),
    .H_FIRST(HF), .V_FIRST(VF), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .locked(locked), .frame_done(frame_done),
    .h_total_m(h_total_m), .h_sync_m(h_sync_m), .v_total_m(v_total_m), .v_sync_m(v_sync_m),
    .frame_checksum(frame_checksum), .err_h(err_h), .err_v(err_v), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [10:0] ht;
    logic [10:0] hsw;
    logic [9:0]  vt;
    logic [9:0]  vsw;
    logic [15:0] cs;
    logic [15:0] fc;
    logic        lk;
    logic        eh;
    logic        ev;
    int          cy;
  } exp_t;

  exp_t sb[$];
  exp_t last, mon_e;
  int checks = 0, failures = 0;

  bit          started;
  int          m_lock, prev_vtot, prev_last_len;
  logic        m_err_h, m_err_v, m_bad;
  logic [15:0] m_csum, m_fc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    started = 1'b0;
    m_lock  = 0;
    m_err_h = 1'b0;
    m_err_v = 1'b0;
    m_bad   = 1'b0;
    m_fc    = '0;
    m_csum  = '0;
    last    = '0;
  endtask

  // Called on the clock where the vs falling edge is driven.
  task automatic frame_start();
    exp_t e;
    if (started) begin
      if (!m_bad && prev_vtot == VT) m_lock = (m_lock < LOCKN) ? m_lock + 1 : m_lock;
      else m_lock = 0;
      if (prev_vtot != VT) m_err_v = 1'b1;
      m_fc  = m_fc + 16'd1;
      e.ht  = 11'(prev_last_len);
      e.hsw = 11'(HSW);
      e.vt  = 10'(prev_vtot);
      e.vsw = 10'(VSW);
`ifdef VGA_MON_CHECKSUM_EN
      e.cs  = m_csum;
`else
      e.cs  = 16'h0000;
`endif
      e.fc  = m_fc;
      e.lk  = (m_lock == LOCKN);
      e.eh  = m_err_h;
      e.ev  = m_err_v;
      e.cy  = cyc + 2;
      sb.push_back(e);
      last = e;
    end
    started = 1'b1;
    m_bad   = 1'b0;
    m_csum  = '0;
  endtask

  task automatic drive_frame(input int vtot, input int bad_line, input int bad_len, input int rst_line);
    logic presat;
    logic act;
    presat = 1'b0;
    for (int vl = 0; vl < vtot; vl++) begin
      int len;
      len = (vl == bad_line) ? bad_len : HT;
      for (int hp = 0; hp < len; hp++) begin
        @(negedge clk);
        if (vl == 0 && hp == 0) frame_start();
        if (hp == 0) begin
          presat = m_err_h;
          if (started && len != HT) begin
            m_bad   = 1'b1;
            m_err_h = 1'b1;
          end
        end
        hs  = (hp < HSW) ? 1'b0 : 1'b1;
        vs  = ((vl < VSW) || (vl == VSW && hp < HSW)) ? 1'b0 : 1'b1;
        act = (hp >= HF) && (hp < HF + HA) && (vl >= VF) && (vl < VF + VA);
        r = act ? 4'hF : 4'h0;
        g = act ? 4'hF : 4'h0;
        b = act ? 4'hF : 4'h0;
        if (act) m_csum = {m_csum[14:0], m_csum[15]} ^ 16'h0FFF;
        if (vl == 10 && hp == 20) begin
          check("hold_frame_cnt", frame_cnt, last.fc);
          check("hold_locked", locked, last.lk);
          check("hold_h_total_m", h_total_m, last.ht);
          check("hold_v_total_m", v_total_m, last.vt);
          check("hold_checksum", frame_checksum, last.cs);
        end
        if (len > 2100 && hp == 1500) check("err_h_presat", err_h, presat);
        if (len > 2100 && hp == 2500) check("err_h_sat", err_h, 1'b1);
        if (vl == rst_line && hp == 5) begin
          rst = 1'b1;
          model_reset();
        end
        if (vl == rst_line && hp == 7) begin
          check("midrst_meas", {h_total_m, h_sync_m, v_total_m, v_sync_m}, 64'd0);
          check("midrst_flags", {locked, frame_done, err_h, err_v, frame_checksum, frame_cnt}, 64'd0);
        end
        if (vl == rst_line && hp == 9) rst = 1'b0;
      end
      prev_last_len = len;
    end
    prev_vtot = vtot;
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      check("frame_done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("frame_done_cycle", cyc, mon_e.cy);
        check("h_total_m", h_total_m, mon_e.ht);
        check("h_sync_m", h_sync_m, mon_e.hsw);
        check("v_total_m", v_total_m, mon_e.vt);
        check("v_sync_m", v_sync_m, mon_e.vsw);
        check("frame_checksum", frame_checksum, mon_e.cs);
        check("frame_cnt", frame_cnt, mon_e.fc);
        check("locked", locked, mon_e.lk);
        check("err_h", err_h, mon_e.eh);
        check("err_v", err_v, mon_e.ev);
      end
    end
  end

  initial begin
    rst = 1'b1;
    hs  = 1'b1;
    vs  = 1'b1;
    r   = 4'h0;
    g   = 4'h0;
    b   = 4'h0;
    prev_vtot = VT;
    prev_last_len = HT;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_meas", {h_total_m, h_sync_m, v_total_m, v_sync_m}, 64'd0);
    check("reset_flags", {locked, frame_done, err_h, err_v, frame_checksum, frame_cnt}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    repeat (4) drive_frame(VT, -1, HT, -1);
    drive_frame(VT, 7, HT + 1, -1);
    repeat (3) drive_frame(VT, -1, HT, -1);
    drive_frame(VT - 1, -1, HT, -1);
    drive_frame(VT, -1, HT, 3);
    drive_frame(VT, -1, HT, -1);
    drive_frame(VT, 8, HSW + 3000, -1);
    drive_frame(3, -1, HT, -1);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
